// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if
//   Bundles every signal exchanged between the EX/MEM stage and the rest of
//   the MIPS datapath: the EX-stage instruction fields and pipeline controls,
//   the ID/WB register numbers used for forwarding, and the registered
//   MEM-side outputs plus the forwarding/hazard feedback.
//   Modports:
//     slave  - the EX/MEM stage itself (consumes ex_*, drives mem_*).
//     master - the surrounding pipeline (drives ex_*, consumes mem_*).
interface ex_mem_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  // EX-side instruction fields
  logic              ex_valid;
  logic [DATA_W-1:0] ex_pc;
  logic [DATA_W-1:0] ex_result;
  logic              ex_zero;
  logic              ex_carry;
  logic              ex_ovf;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_ovf_trap_en;
  logic              ex_branch;
  logic              ex_branch_ne;

  // Pipeline control
  logic              stall;
  logic              flush;
  logic              ovf_clr;

  // Forwarding inputs
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_reg_write;

  // MEM-side outputs
  logic              mem_valid;
  logic [DATA_W-1:0] mem_pc;
  logic [DATA_W-1:0] mem_result;
  logic [DATA_W-1:0] mem_store_data;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_reg_write;
  logic              mem_mem_read;
  logic              mem_mem_write;
  logic [2:0]        mem_flags;
  logic              branch_taken;
  logic              exc_ovf;
  logic [DATA_W-1:0] exc_pc;
  logic              ovf_status;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              load_use_hazard;

  modport slave (
    input  ex_valid, ex_pc, ex_result, ex_zero, ex_carry, ex_ovf,
           ex_store_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_ovf_trap_en, ex_branch, ex_branch_ne,
           stall, flush, ovf_clr,
           id_rs, id_rt, wb_rd, wb_reg_write,
    output mem_valid, mem_pc, mem_result, mem_store_data, mem_rd,
           mem_reg_write, mem_mem_read, mem_mem_write, mem_flags,
           branch_taken, exc_ovf, exc_pc, ovf_status,
           fwd_a, fwd_b, load_use_hazard
  );

  modport master (
    output ex_valid, ex_pc, ex_result, ex_zero, ex_carry, ex_ovf,
           ex_store_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_ovf_trap_en, ex_branch, ex_branch_ne,
           stall, flush, ovf_clr,
           id_rs, id_rt, wb_rd, wb_reg_write,
    input  mem_valid, mem_pc, mem_result, mem_store_data, mem_rd,
           mem_reg_write, mem_mem_read, mem_mem_write, mem_flags,
           branch_taken, exc_ovf, exc_pc, ovf_status,
           fwd_a, fwd_b, load_use_hazard
  );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage
//   EX/MEM pipeline register for the 32-bit MIPS datapath. Captures the ALU
//   result, flags and control bits one cycle after execute, traps signed
//   overflow (masking register/memory writes, pulsing exc_ovf, latching the
//   trapping PC and a sticky status bit), resolves beq/bne, and produces the
//   combinational operand-forwarding selects and load-use hazard flag.
//   Ports:
//     clk   - rising-edge clock
//     rst_n - synchronous active-low reset
//     bus   - ex_mem_stage_if slave modport (all datapath signals)
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  ex_mem_stage_if.slave  bus
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  logic              mem_valid_q,      mem_valid_d;
  logic [DATA_W-1:0] mem_pc_q,         mem_pc_d;
  logic [DATA_W-1:0] mem_result_q,     mem_result_d;
  logic [DATA_W-1:0] mem_store_data_q, mem_store_data_d;
  logic [REG_AW-1:0] mem_rd_q,         mem_rd_d;
  logic              mem_reg_write_q,  mem_reg_write_d;
  logic              mem_mem_read_q,   mem_mem_read_d;
  logic              mem_mem_write_q,  mem_mem_write_d;
  logic [2:0]        mem_flags_q,      mem_flags_d;
  logic              branch_taken_q,   branch_taken_d;
  logic              exc_ovf_q,        exc_ovf_d;
  logic [DATA_W-1:0] exc_pc_q,         exc_pc_d;
  logic              ovf_status_q,     ovf_status_d;

  logic trap;

  // Overflow only traps for a real instruction that asked for it.
  assign trap = bus.ex_valid & bus.ex_ovf_trap_en & bus.ex_ovf;

  always_comb begin
    mem_valid_d      = mem_valid_q;
    mem_pc_d         = mem_pc_q;
    mem_result_d     = mem_result_q;
    mem_store_data_d = mem_store_data_q;
    mem_rd_d         = mem_rd_q;
    mem_reg_write_d  = mem_reg_write_q;
    mem_mem_read_d   = mem_mem_read_q;
    mem_mem_write_d  = mem_mem_write_q;
    mem_flags_d      = mem_flags_q;
    exc_pc_d         = exc_pc_q;
    // Pulses drop on every non-capturing edge so they never repeat.
    branch_taken_d   = 1'b0;
    exc_ovf_d        = 1'b0;
    ovf_status_d     = bus.ovf_clr ? 1'b0 : ovf_status_q;

    if (bus.flush) begin
      // Bubble: data registers keep their stale contents.
      mem_valid_d     = 1'b0;
      mem_reg_write_d = 1'b0;
      mem_mem_read_d  = 1'b0;
      mem_mem_write_d = 1'b0;
    end else if (!bus.stall) begin
      mem_valid_d      = bus.ex_valid;
      mem_pc_d         = bus.ex_pc;
      mem_result_d     = bus.ex_result;
      mem_store_data_d = bus.ex_store_data;
      mem_rd_d         = bus.ex_rd;
      mem_flags_d      = {bus.ex_carry, bus.ex_ovf, bus.ex_zero};
      // A trap kills the architectural side effects but leaves a load's
      // read strobe alone (reads are side-effect free).
      mem_reg_write_d  = bus.ex_valid & bus.ex_reg_write & ~trap;
      mem_mem_write_d  = bus.ex_valid & bus.ex_mem_write & ~trap;
      mem_mem_read_d   = bus.ex_valid & bus.ex_mem_read;
      // beq takes on zero, bne on non-zero.
      branch_taken_d   = bus.ex_valid & bus.ex_branch &
                         (bus.ex_zero ^ bus.ex_branch_ne);
      exc_ovf_d        = trap;
      if (trap) begin
        exc_pc_d     = bus.ex_pc;
        ovf_status_d = 1'b1;  // set beats a simultaneous clear
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_valid_q      <= 1'b0;
      mem_pc_q         <= '0;
      mem_result_q     <= '0;
      mem_store_data_q <= '0;
      mem_rd_q         <= '0;
      mem_reg_write_q  <= 1'b0;
      mem_mem_read_q   <= 1'b0;
      mem_mem_write_q  <= 1'b0;
      mem_flags_q      <= '0;
      branch_taken_q   <= 1'b0;
      exc_ovf_q        <= 1'b0;
      exc_pc_q         <= '0;
      ovf_status_q     <= 1'b0;
    end else begin
      mem_valid_q      <= mem_valid_d;
      mem_pc_q         <= mem_pc_d;
      mem_result_q     <= mem_result_d;
      mem_store_data_q <= mem_store_data_d;
      mem_rd_q         <= mem_rd_d;
      mem_reg_write_q  <= mem_reg_write_d;
      mem_mem_read_q   <= mem_mem_read_d;
      mem_mem_write_q  <= mem_mem_write_d;
      mem_flags_q      <= mem_flags_d;
      branch_taken_q   <= branch_taken_d;
      exc_ovf_q        <= exc_ovf_d;
      exc_pc_q         <= exc_pc_d;
      ovf_status_q     <= ovf_status_d;
    end
  end

  // A load in EX/MEM has no result yet, so it is excluded from EX/MEM
  // forwarding; the hazard flag stalls upstream instead.
  logic mem_can_fwd;
  assign mem_can_fwd = mem_valid_q & mem_reg_write_q & ~mem_mem_read_q &
                       (mem_rd_q != '0);

  function automatic logic [1:0] fwd_sel(
    input logic              mem_ok,
    input logic [REG_AW-1:0] mem_rd,
    input logic              wb_we,
    input logic [REG_AW-1:0] wb_rd,
    input logic [REG_AW-1:0] src
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (mem_ok && (mem_rd == src))
      sel = FWD_MEM;
    else if (wb_we && (wb_rd != '0) && (wb_rd == src))
      sel = FWD_WB;
    return sel;
  endfunction

  always_comb begin
    bus.fwd_a = fwd_sel(mem_can_fwd, mem_rd_q, bus.wb_reg_write, bus.wb_rd,
                        bus.id_rs);
    bus.fwd_b = fwd_sel(mem_can_fwd, mem_rd_q, bus.wb_reg_write, bus.wb_rd,
                        bus.id_rt);
  end

  assign bus.load_use_hazard = mem_valid_q & mem_mem_read_q & (mem_rd_q != '0) &
                               ((mem_rd_q == bus.id_rs) | (mem_rd_q == bus.id_rt));

  assign bus.mem_valid      = mem_valid_q;
  assign bus.mem_pc         = mem_pc_q;
  assign bus.mem_result     = mem_result_q;
  assign bus.mem_store_data = mem_store_data_q;
  assign bus.mem_rd         = mem_rd_q;
  assign bus.mem_reg_write  = mem_reg_write_q;
  assign bus.mem_mem_read   = mem_mem_read_q;
  assign bus.mem_mem_write  = mem_mem_write_q;
  assign bus.mem_flags      = mem_flags_q;
  assign bus.branch_taken   = branch_taken_q;
  assign bus.exc_ovf        = exc_ovf_q;
  assign bus.exc_pc         = exc_pc_q;
  assign bus.ovf_status     = ovf_status_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage
//   Directed scenarios followed by randomized traffic, all checked against a
//   behavioural model of the EX/MEM stage kept in this bench.
module tb_ex_mem_stage;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  ex_mem_stage_if #(.DATA_W(32), .REG_AW(5)) bus_if ();

  ex_mem_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // ---------------- reference model state (expected outputs) -------------
  logic        m_valid, m_rw, m_mr, m_mw, m_br, m_exc, m_st;
  logic [31:0] m_pc, m_res, m_sd, m_epc;
  logic [4:0]  m_rd;
  logic [2:0]  m_flags;

  task automatic model_edge();
    logic is_trap;
    if (!rst_n) begin
      {m_valid, m_rw, m_mr, m_mw, m_br, m_exc, m_st} = '0;
      m_pc = 0; m_res = 0; m_sd = 0; m_epc = 0; m_rd = 0; m_flags = 0;
      return;
    end
    m_br  = 0;
    m_exc = 0;
    if (bus_if.flush || bus_if.stall) begin
      if (bus_if.flush) begin
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
      end
      if (bus_if.ovf_clr) m_st = 0;
      return;
    end
    is_trap = bus_if.ex_valid && bus_if.ex_ovf_trap_en && bus_if.ex_ovf;
    m_valid = bus_if.ex_valid;
    m_pc    = bus_if.ex_pc;
    m_res   = bus_if.ex_result;
    m_sd    = bus_if.ex_store_data;
    m_rd    = bus_if.ex_rd;
    m_flags = {bus_if.ex_carry, bus_if.ex_ovf, bus_if.ex_zero};
    m_mr    = bus_if.ex_valid && bus_if.ex_mem_read;
    m_rw    = bus_if.ex_valid && bus_if.ex_reg_write && !is_trap;
    m_mw    = bus_if.ex_valid && bus_if.ex_mem_write && !is_trap;
    if (bus_if.ex_valid && bus_if.ex_branch)
      m_br = bus_if.ex_branch_ne ? !bus_if.ex_zero : bus_if.ex_zero;
    if (is_trap) begin
      m_exc = 1; m_epc = bus_if.ex_pc; m_st = 1;
    end else if (bus_if.ovf_clr) begin
      m_st = 0;
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    if (m_valid && m_rw && !m_mr && m_rd != 0 && m_rd == src) return 2'b10;
    if (bus_if.wb_reg_write && bus_if.wb_rd != 0 && bus_if.wb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic exp_hazard();
    return m_valid && m_mr && m_rd != 0 &&
           (m_rd == bus_if.id_rs || m_rd == bus_if.id_rt);
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_all();
    check("mem_valid", 64'(bus_if.mem_valid), 64'(m_valid));
    check("mem_reg_write", 64'(bus_if.mem_reg_write), 64'(m_rw));
    check("mem_mem_read", 64'(bus_if.mem_mem_read), 64'(m_mr));
    check("mem_mem_write", 64'(bus_if.mem_mem_write), 64'(m_mw));
    check("branch_taken", 64'(bus_if.branch_taken), 64'(m_br));
    check("exc_ovf", 64'(bus_if.exc_ovf), 64'(m_exc));
    check("exc_pc", 64'(bus_if.exc_pc), 64'(m_epc));
    check("ovf_status", 64'(bus_if.ovf_status), 64'(m_st));
    if (m_valid) begin
      check("mem_pc", 64'(bus_if.mem_pc), 64'(m_pc));
      check("mem_result", 64'(bus_if.mem_result), 64'(m_res));
      check("mem_store_data", 64'(bus_if.mem_store_data), 64'(m_sd));
      check("mem_rd", 64'(bus_if.mem_rd), 64'(m_rd));
      check("mem_flags", 64'(bus_if.mem_flags), 64'(m_flags));
    end
    check("fwd_a", 64'(bus_if.fwd_a), 64'(exp_fwd(bus_if.id_rs)));
    check("fwd_b", 64'(bus_if.fwd_b), 64'(exp_fwd(bus_if.id_rt)));
    check("load_use_hazard", 64'(bus_if.load_use_hazard), 64'(exp_hazard()));
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check_all();
    $display("cyc %0d rst_n=%0b stall=%0b flush=%0b clr=%0b | valid=%0b pc=%h res=%h rd=%0d rw=%0b mr=%0b mw=%0b br=%0b exc=%0b st=%0b fa=%b fb=%b lu=%0b",
             cyc, rst_n, bus_if.stall, bus_if.flush, bus_if.ovf_clr,
             bus_if.mem_valid, bus_if.mem_pc, bus_if.mem_result, bus_if.mem_rd,
             bus_if.mem_reg_write, bus_if.mem_mem_read, bus_if.mem_mem_write,
             bus_if.branch_taken, bus_if.exc_ovf, bus_if.ovf_status,
             bus_if.fwd_a, bus_if.fwd_b, bus_if.load_use_hazard);
  endtask

  task automatic idle();
    bus_if.ex_valid = 0; bus_if.ex_pc = 0; bus_if.ex_result = 0;
    bus_if.ex_zero = 0; bus_if.ex_carry = 0; bus_if.ex_ovf = 0;
    bus_if.ex_store_data = 0; bus_if.ex_rd = 0;
    bus_if.ex_reg_write = 0; bus_if.ex_mem_read = 0; bus_if.ex_mem_write = 0;
    bus_if.ex_ovf_trap_en = 0; bus_if.ex_branch = 0; bus_if.ex_branch_ne = 0;
    bus_if.stall = 0; bus_if.flush = 0; bus_if.ovf_clr = 0;
    bus_if.id_rs = 0; bus_if.id_rt = 0; bus_if.wb_rd = 0; bus_if.wb_reg_write = 0;
  endtask

  task automatic instr(input logic [31:0] pc, input logic [31:0] res,
                       input logic [4:0] rd, input logic rw, input logic mr,
                       input logic mw);
    bus_if.ex_valid = 1; bus_if.ex_pc = pc; bus_if.ex_result = res;
    bus_if.ex_store_data = res ^ 32'hA5A5_0000; bus_if.ex_rd = rd;
    bus_if.ex_reg_write = rw; bus_if.ex_mem_read = mr; bus_if.ex_mem_write = mw;
    bus_if.ex_zero = 0; bus_if.ex_carry = 0; bus_if.ex_ovf = 0;
    bus_if.ex_ovf_trap_en = 0; bus_if.ex_branch = 0; bus_if.ex_branch_ne = 0;
  endtask

  task automatic randomize_inputs();
    rst_n                 = ($urandom_range(63) != 0);
    bus_if.ex_valid       = ($urandom_range(7) != 0);
    bus_if.ex_pc          = $urandom & 32'hFFFF_FFFC;
    bus_if.ex_result      = $urandom;
    bus_if.ex_store_data  = $urandom;
    bus_if.ex_zero        = 1'($urandom);
    bus_if.ex_carry       = 1'($urandom);
    bus_if.ex_ovf         = ($urandom_range(2) == 0);
    bus_if.ex_rd          = 5'($urandom_range(3));
    bus_if.ex_reg_write   = 1'($urandom);
    bus_if.ex_mem_read    = ($urandom_range(3) == 0);
    bus_if.ex_mem_write   = ($urandom_range(3) == 0);
    bus_if.ex_ovf_trap_en = 1'($urandom);
    bus_if.ex_branch      = ($urandom_range(3) == 0);
    bus_if.ex_branch_ne   = 1'($urandom);
    bus_if.stall          = ($urandom_range(7) == 0);
    bus_if.flush          = ($urandom_range(9) == 0);
    bus_if.ovf_clr        = ($urandom_range(7) == 0);
    bus_if.id_rs          = 5'($urandom_range(3));
    bus_if.id_rt          = 5'($urandom_range(3));
    bus_if.wb_rd          = 5'($urandom_range(3));
    bus_if.wb_reg_write   = 1'($urandom);
  endtask

  initial begin
    idle();
    rst_n = 0;
    step(); step();
    rst_n = 1;

    // Reset mid-stream
    instr(32'h0040_0000, 32'h0000_0005, 5'd3, 1, 0, 0);
    step();
    check("add_result", 64'(bus_if.mem_result), 64'h5);
    bus_if.wb_rd = 5'd3; bus_if.id_rs = 5'd3;
    rst_n = 0;
    step();
    rst_n = 1;
    check("rst_valid", 64'(bus_if.mem_valid), 64'h0);
    check("rst_result", 64'(bus_if.mem_result), 64'h0);
    check("rst_pc", 64'(bus_if.mem_pc), 64'h0);
    check("rst_fwd_a", 64'(bus_if.fwd_a), 64'h0);
    check("rst_fwd_b", 64'(bus_if.fwd_b), 64'h0);

    // Signed overflow trap, then same inputs with trapping disabled
    instr(32'h0040_0010, 32'h8000_0000, 5'd4, 1, 0, 0);
    bus_if.ex_ovf = 1; bus_if.ex_ovf_trap_en = 1;
    step();
    check("trap_rw", 64'(bus_if.mem_reg_write), 64'h0);
    check("trap_exc", 64'(bus_if.exc_ovf), 64'h1);
    check("trap_pc", 64'(bus_if.exc_pc), 64'h0040_0010);
    check("trap_status", 64'(bus_if.ovf_status), 64'h1);
    bus_if.ex_ovf_trap_en = 0;
    step();
    check("notrap_rw", 64'(bus_if.mem_reg_write), 64'h1);
    check("notrap_exc", 64'(bus_if.exc_ovf), 64'h0);

    // Stall for three cycles, then flush overriding stall
    instr(32'h0040_0020, 32'h0000_00FF, 5'd5, 1, 0, 0);
    step();
    bus_if.stall = 1;
    instr(32'h0040_0024, 32'h1234_5678, 5'd6, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_result", 64'(bus_if.mem_result), 64'hFF);
      check("stall_exc", 64'(bus_if.exc_ovf), 64'h0);
    end
    bus_if.flush = 1;
    step();
    check("flush_valid", 64'(bus_if.mem_valid), 64'h0);
    check("flush_rw", 64'(bus_if.mem_reg_write), 64'h0);
    bus_if.flush = 0; bus_if.stall = 0;

    // Forwarding priority and register 0
    instr(32'h0040_0030, 32'h0000_0011, 5'd8, 1, 0, 0);
    bus_if.wb_rd = 5'd8; bus_if.wb_reg_write = 1; bus_if.id_rs = 5'd8;
    step();
    check("fwd_mem", 64'(bus_if.fwd_a), 64'h2);
    instr(32'h0040_0034, 32'h0000_0022, 5'd0, 1, 0, 0);
    step();
    check("fwd_wb", 64'(bus_if.fwd_a), 64'h1);
    bus_if.id_rt = 5'd0; bus_if.wb_rd = 5'd0;
    #1;
    check("fwd_r0", 64'(bus_if.fwd_b), 64'h0);

    // Load-use hazard
    instr(32'h0040_0040, 32'h0000_1000, 5'd9, 1, 1, 0);
    bus_if.wb_reg_write = 0; bus_if.id_rt = 5'd9; bus_if.id_rs = 5'd1;
    step();
    check("lu_hazard", 64'(bus_if.load_use_hazard), 64'h1);
    check("lu_fwd_b_not10", 64'(bus_if.fwd_b == 2'b10), 64'h0);
    bus_if.ex_valid = 0;
    step();
    check("lu_clear", 64'(bus_if.load_use_hazard), 64'h0);

    // Branches
    instr(32'h0040_0050, 32'h0, 5'd0, 0, 0, 0);
    bus_if.ex_branch = 1; bus_if.ex_zero = 1;
    step();
    check("beq_taken", 64'(bus_if.branch_taken), 64'h1);
    bus_if.ex_branch_ne = 1;
    step();
    check("bne_not_taken", 64'(bus_if.branch_taken), 64'h0);

    // Sticky overflow: set wins over clear, then clear alone
    idle();
    instr(32'h0040_0060, 32'h7FFF_FFFF, 5'd2, 1, 0, 0);
    bus_if.ex_ovf = 1; bus_if.ex_ovf_trap_en = 1; bus_if.ovf_clr = 1;
    step();
    check("clr_vs_set", 64'(bus_if.ovf_status), 64'h1);
    idle();
    bus_if.ovf_clr = 1;
    step();
    check("clr_alone", 64'(bus_if.ovf_status), 64'h0);
    bus_if.ovf_clr = 0;

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      randomize_inputs();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

EX/MEM pipeline stage for the 32-bit MIPS datapath. It registers the ALU result, the Zero/carry/overflow flags and the EX-stage control bits on the clock edge after execute, then presents them to the data-memory stage. It also traps signed-arithmetic overflow, resolves branches, and drives the operand-forwarding selects and load-use hazard flag back to the ALU operand muxes.

## Interface
- DATA_W, 32, datapath width; ALU result and store data.
- REG_AW, 5, register-number width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- ex_valid  in  1  EX slot holds a real instruction.
- ex_pc  in  DATA_W  PC of the EX instruction.
- ex_result  in  DATA_W  ALU result.
- ex_zero, ex_carry, ex_ovf  in  1 each  ALU Zero, carry-out of bit 31, and signed overflow (carry31 XOR carry30).
- ex_store_data  in  DATA_W  rt value for stores.
- ex_rd  in  REG_AW  destination register.
- ex_reg_write, ex_mem_read, ex_mem_write  in  1 each  control bits.
- ex_ovf_trap_en  in  1  instruction is add/sub/addi, so overflow traps.
- ex_branch, ex_branch_ne  in  1 each  beq when only ex_branch is high; bne when both are high.
- stall  in  1  hold all stage registers.
- flush  in  1  squash; load a bubble.
- ovf_clr  in  1  clear the sticky overflow status.
- id_rs, id_rt  in  REG_AW  source registers of the instruction now entering EX.
- wb_rd  in  REG_AW  MEM/WB destination register.
- wb_reg_write  in  1  MEM/WB write enable.
- mem_valid  out  1  registered valid.
- mem_pc  out  DATA_W  registered PC.
- mem_result, mem_store_data  out  DATA_W  registered data.
- mem_rd  out  REG_AW  registered destination register.
- mem_reg_write, mem_mem_read, mem_mem_write  out  1 each  registered control bits, after trap masking.
- mem_flags  out  3  {carry, ovf, zero}, registered.
- branch_taken  out  1  registered branch decision.
- exc_ovf  out  1  one-cycle overflow-trap pulse.
- exc_pc  out  DATA_W  PC of the last trapping instruction.
- ovf_status  out  1  sticky overflow flag.
- fwd_a, fwd_b  out  2  operand select: 00 register file, 10 EX/MEM result, 01 MEM/WB.
- load_use_hazard  out  1  request to stall upstream.

## Operation
- Reset (rst_n=0 at the edge): every registered output goes to 0. This covers mem_valid, mem_pc, data, mem_rd, controls, flags, branch_taken, exc_ovf, exc_pc and ovf_status.
- Each edge, priority order is reset, then flush, then stall, then capture.
- flush=1: load a bubble. mem_valid and all control bits go to 0; exc_ovf and branch_taken go to 0. Data registers are don't-care (implementation holds them); exc_pc holds; ovf_status holds unless ovf_clr is high.
- stall=1 (no flush): all pipeline registers hold. exc_ovf and branch_taken go to 0 so no pulse repeats; ovf_status still obeys ovf_clr.
- Capture: copy all ex_* fields; mem_valid ← ex_valid.
- Any capture with ex_valid=0 forces all controls, exc_ovf and branch_taken to 0.
- Trap condition: ex_valid & ex_ovf_trap_en & ex_ovf.
  - mem_reg_write and mem_mem_write are forced to 0; mem_mem_read passes through unchanged.
  - exc_ovf=1 for exactly one cycle.
  - exc_pc ← ex_pc.
  - ovf_status ← 1. When ovf_clr and a trap land on the same edge, the set wins.
- Unsigned ops (ex_ovf_trap_en=0) never trap. The flags are still captured.
- branch_taken ← ex_valid & ex_branch & (ex_zero XOR ex_branch_ne).
- Forwarding is combinational from the registered mem_* values and the wb_* inputs. fwd_b is the same logic using id_rt.
  - fwd_a=10 when mem_valid & mem_reg_write & !mem_mem_read & mem_rd≠0 & mem_rd==id_rs.
  - Otherwise fwd_a=01 when wb_reg_write & wb_rd≠0 & wb_rd==id_rs.
  - Otherwise fwd_a=00.
  - EX/MEM has priority over MEM/WB; register 0 is never forwarded.
- load_use_hazard = mem_valid & mem_mem_read & mem_rd≠0 & (mem_rd==id_rs | mem_rd==id_rt). Combinational.

## Timing
- Latency is 1 cycle: ex_* sampled at edge N appear on mem_* after edge N.
- exc_ovf and branch_taken are single-cycle pulses aligned with the corresponding mem_valid.
- fwd_*, load_use_hazard: zero-cycle combinational paths from registered state; no ex_* input feeds them.
- Throughput is one instruction per cycle when stall=0.

## Test plan
- Reset mid-stream: capture valid add (result 0x0000_0005), then rst_n=0 for one edge → all outputs 0; fwd_a=fwd_b=00.
- Signed overflow: ex_result=0x8000_0000, ex_ovf=1, ex_ovf_trap_en=1, ex_reg_write=1, ex_pc=0x0040_0010 → next cycle mem_reg_write=0, exc_ovf=1 (then 0), exc_pc=0x0040_0010, ovf_status=1. The same inputs with trap_en=0 give mem_reg_write=1 and exc_ovf=0.
- Stall/flush: capture sub 0x0000_00FF, then hold stall=1 for 3 cycles → outputs stable, exc_ovf=0. Then flush=1 together with stall=1 → mem_valid=0 and controls 0.
- Forwarding: mem_rd=8 with mem_reg_write=1, wb_rd=8 with wb_reg_write=1, id_rs=8 → fwd_a=10. Set mem_rd=0 → fwd_a=01. Set id_rt=0 with wb_rd=0 → fwd_b=00.
- Load-use: mem_mem_read=1, mem_rd=9, id_rt=9 → load_use_hazard=1 and fwd_b≠10. Set mem_valid=0 → load_use_hazard=0.
- Branch and sticky clear: beq with ex_zero=1 → branch_taken=1. bne with ex_zero=1 → branch_taken=0. Assert ovf_clr on the same edge as a trap → ovf_status=1; ovf_clr alone on the next edge → ovf_status=0.
